spinner_accum: RTL and testbench

Rotary-position accumulator for dial-controlled games such as Kick. Accepts two control sources: hps_io spinner packets (9-bit, toggle plus signed delta) and digital left/right/fast buttons, stepped once per video frame. Produces a wrapping OUT_W-bit dial angle that the top level packs directly into mcr1 input_1. Sits between hps_io/joystick decode and the mcr1 input mux; it replaces the generic spinner instance.

---
 rtl/spinner_pkg.sv | 18 +
 rtl/spinner_accum_if.sv | 18 +
 rtl/spinner_edge.sv | 29 ++
 rtl/spinner_accum.sv | 81 ++++++++
 tb/tb_spinner_accum.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/spinner_pkg.sv
// Shared widths and helpers for the spinner dial accumulator.
package spinner_pkg;

  localparam int OUT_W_DEF  = 4;
  localparam int FRAC_W_DEF = 3;

  function automatic int acc_width(input int out_w, input int frac_w);
    return out_w + frac_w;
  endfunction

  // Symmetric clamp so a single large hps_io packet cannot spin the dial wildly.
  function automatic int clamp_delta(input int delta, input int max_delta);
    if (delta > max_delta) return max_delta;
    if (delta < -max_delta) return -max_delta;
    return delta;
  endfunction

endpackage

// File: rtl/spinner_accum_if.sv
// Control inputs and dial angle output between joystick decode and the mcr1 input mux.
interface spinner_accum_if
  import spinner_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
);
  logic             fast;
  logic             minus;
  logic             plus;
  logic             strobe;
  logic [8:0]       spin_in;
  logic [OUT_W-1:0] spin_out;

  modport master (output fast, output minus, output plus, output strobe, output spin_in,
                  input spin_out);
  modport slave  (input fast, input minus, input plus, input strobe, input spin_in,
                  output spin_out);
endinterface

// File: rtl/spinner_edge.sv
// Frame-strobe rising-edge detect and hps_io toggle-change detect.
module spinner_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic tog,
  output logic strobe_evt,
  output logic tog_evt
);
  logic strobe_d;
  logic tog_d;
  logic primed;

  // primed holds off the first cycle so a toggle level present at reset release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_d <= 1'b0;
      tog_d    <= 1'b0;
      primed   <= 1'b0;
    end else begin
      strobe_d <= strobe;
      tog_d    <= tog;
      primed   <= 1'b1;
    end
  end

  assign strobe_evt = strobe & ~strobe_d;
  assign tog_evt    = primed & (tog != tog_d);
endmodule

// File: rtl/spinner_accum.sv
// Rotary dial accumulator: analog hps_io deltas plus per-frame digital steps.
// Optional hold acceleration is enabled with `define SPINNER_ACCEL_EN.
module spinner_accum
  import spinner_pkg::*;
#(
  parameter int OUT_W        = OUT_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int DIG_STEP     = 2,
  parameter int FAST_SHIFT   = 2,
  parameter int MAX_DELTA    = 64,
  parameter int ACCEL_FRAMES = 16
) (
  input logic             clk,
  input logic             reset,
  spinner_accum_if.slave  bus
);
  localparam int ACC_W = acc_width(OUT_W, FRAC_W);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] analog_term;
  logic [ACC_W-1:0] digital_term;
  logic             strobe_evt;
  logic             tog_evt;
  logic             accel;
  int               step;

  spinner_edge u_edge (
    .clk        (clk),
    .reset      (reset),
    .strobe     (bus.strobe),
    .tog        (bus.spin_in[8]),
    .strobe_evt (strobe_evt),
    .tog_evt    (tog_evt)
  );

`ifdef SPINNER_ACCEL_EN
  localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_dir;

  // hold_dir remembers which way is being counted so a reversal restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      hold_dir <= 1'b0;
    end else if (bus.plus == bus.minus) begin
      hold_cnt <= '0;
    end else if (bus.plus != hold_dir) begin
      hold_dir <= bus.plus;
      hold_cnt <= strobe_evt ? HOLD_W'(1) : '0;
    end else if (strobe_evt && (hold_cnt != HOLD_W'(ACCEL_FRAMES))) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign accel = (hold_cnt == HOLD_W'(ACCEL_FRAMES)) && (bus.plus == hold_dir);
`else
  assign accel = 1'b0;
`endif

  always_comb begin
    step = bus.fast ? (DIG_STEP << FAST_SHIFT) : DIG_STEP;
    if (accel) step = step << 1;

    digital_term = '0;
    if (strobe_evt && bus.plus && !bus.minus) digital_term = ACC_W'(step);
    else if (strobe_evt && bus.minus && !bus.plus) digital_term = ACC_W'(-step);

    analog_term = '0;
    if (tog_evt) analog_term = ACC_W'(clamp_delta(int'($signed(bus.spin_in[7:0])), MAX_DELTA));
  end

  // Both terms land in the same add so simultaneous analog and digital events both count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc + analog_term + digital_term;
  end

  assign bus.spin_out = acc[ACC_W-1:FRAC_W];
endmodule

// File: tb/tb_spinner_accum.sv
// Directed-vector bench for spinner_accum (default parameters, accel optional).
module tb_spinner_accum;
  import spinner_pkg::*;

  typedef struct {
    bit         plus;
    bit         minus;
    bit         fast;
    bit         tog;
    logic [7:0] delta;
    bit         strobe;
    logic [6:0] exp_acc;
    string      name;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[19];

  spinner_accum_if #(.OUT_W(4)) bus ();

  spinner_accum dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp_acc);
    logic [3:0] exp_out;
    exp_out = exp_acc[6:3];
    total++;
    if (dut.acc !== exp_acc) begin
      bad++;
      $display("[TB] FAIL %s acc: got %0d expected %0d", name, dut.acc, exp_acc);
    end
    total++;
    if (bus.spin_out !== exp_out) begin
      bad++;
      $display("[TB] FAIL %s spin_out: got %0d expected %0d", name, bus.spin_out, exp_out);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.plus  = v.plus;
    bus.minus = v.minus;
    bus.fast  = v.fast;
    if (v.tog) bus.spin_in = {~bus.spin_in[8], v.delta};
    bus.strobe = v.strobe;
    tick(1);
    bus.strobe = 1'b0;
    tick(1);
  endtask

  task automatic pulseStrobe();
    bus.strobe = 1'b1;
    tick(1);
    bus.strobe = 1'b0;
    tick(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //             plus minus fast tog delta   strb exp  name
    vecs[0]  = '{1, 0, 0, 0, 8'h00, 1, 7'd2,   "plus1"};
    vecs[1]  = '{1, 0, 0, 0, 8'h00, 1, 7'd4,   "plus2"};
    vecs[2]  = '{1, 0, 0, 0, 8'h00, 1, 7'd6,   "plus3"};
    vecs[3]  = '{1, 0, 0, 0, 8'h00, 1, 7'd8,   "plus4"};
    vecs[4]  = '{0, 1, 1, 0, 8'h00, 1, 7'd0,   "fast_minus"};
    vecs[5]  = '{0, 1, 1, 0, 8'h00, 1, 7'd120, "wrap_down"};
    vecs[6]  = '{0, 0, 0, 1, 8'h18, 0, 7'd16,  "analog_pos"};
    vecs[7]  = '{0, 0, 0, 1, 8'h80, 0, 7'd80,  "clamp_neg"};
    vecs[8]  = '{1, 1, 0, 0, 8'h00, 1, 7'd80,  "both_held"};
    vecs[9]  = '{1, 0, 1, 0, 8'h00, 1, 7'd88,  "fast_plus"};
    vecs[10] = '{0, 0, 0, 1, 8'h7F, 0, 7'd24,  "clamp_pos"};
    vecs[11] = '{0, 0, 0, 1, 8'hC1, 0, 7'd89,  "analog_neg"};
    vecs[12] = '{1, 0, 0, 1, 8'h08, 1, 7'd99,  "same_clk"};
    vecs[13] = '{0, 1, 1, 1, 8'h40, 1, 7'd27,  "same_clk_mix"};
    vecs[14] = '{0, 0, 0, 0, 8'h00, 1, 7'd27,  "no_dir"};
    vecs[15] = '{0, 0, 0, 1, 8'h5D, 0, 7'd91,  "clamp_pos2"};
    vecs[16] = '{0, 0, 0, 1, 8'h1D, 0, 7'd120, "analog_29"};
    vecs[17] = '{1, 0, 1, 0, 8'h00, 1, 7'd0,   "wrap_up"};
    vecs[18] = '{1, 0, 0, 0, 8'h00, 0, 7'd0,   "no_strobe"};

    reset       = 1'b1;
    bus.plus    = 1'b0;
    bus.minus   = 1'b0;
    bus.fast    = 1'b0;
    bus.strobe  = 1'b0;
    bus.spin_in = 9'h000;
    tick(2);
    checkOutput("reset", 7'd0);
    reset = 1'b0;
    tick(2);
    checkOutput("after_release", 7'd0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].exp_acc);
    end

    bus.plus  = 1'b1;
    bus.minus = 1'b1;
    bus.fast  = 1'b0;
    for (int i = 0; i < 10; i++) pulseStrobe();
    checkOutput("both_10", 7'd0);

    // A long strobe must count as a single frame.
    bus.minus  = 1'b0;
    bus.strobe = 1'b1;
    tick(100);
    bus.strobe = 1'b0;
    tick(1);
    checkOutput("held_strobe", 7'd2);

    bus.fast = 1'b1;
    pulseStrobe();
    bus.fast = 1'b0;
    bus.plus = 1'b0;
    checkOutput("pre_reset", 7'd10);

    reset       = 1'b1;
    bus.spin_in = 9'h108;
    #1;
    checkOutput("async_reset", 7'd0);
    tick(2);
    reset = 1'b0;
    tick(3);
    checkOutput("no_prime_count", 7'd0);
    bus.spin_in = 9'h008;
    tick(1);
    checkOutput("post_reset_toggle", 7'd8);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    bus.plus = 1'b1;
    for (int i = 0; i < 20; i++) pulseStrobe();
`ifdef SPINNER_ACCEL_EN
    checkOutput("accel_20", 7'd48);
`else
    checkOutput("hold_20", 7'd40);
`endif
    bus.plus = 1'b0;
    tick(2);
    bus.plus = 1'b1;
    pulseStrobe();
`ifdef SPINNER_ACCEL_EN
    checkOutput("accel_restart", 7'd50);
`else
    checkOutput("hold_restart", 7'd42);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
